// File: rtl/sine_lut.sv
// sine_lut: quarter-wave sine magnitude generator for the carrier NCO.
// A 13-bit first-quadrant phase index is split into a 7-bit table index and a 6-bit
// fraction; the 129-point table is linearly interpolated with truncation.
// Build option: define SINE_LUT_PIPE_EN to register the output (1-cycle latency,
// asynchronously cleared by rst). Default build is purely combinational.
`timescale 1ns/1ps
module sine_lut (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] v,
  output logic [15:0] sv
);

  // round(32767 * sin(pi/2 * n / 128)) for n = 0..128
  function automatic logic [14:0] quarter_sine(input logic [7:0] n);
    logic [14:0] t;
    case (n)
      8'd0:   t = 15'd0;
      8'd1:   t = 15'd402;
      8'd2:   t = 15'd804;
      8'd3:   t = 15'd1206;
      8'd4:   t = 15'd1608;
      8'd5:   t = 15'd2009;
      8'd6:   t = 15'd2410;
      8'd7:   t = 15'd2811;
      8'd8:   t = 15'd3212;
      8'd9:   t = 15'd3612;
      8'd10:  t = 15'd4011;
      8'd11:  t = 15'd4410;
      8'd12:  t = 15'd4808;
      8'd13:  t = 15'd5205;
      8'd14:  t = 15'd5602;
      8'd15:  t = 15'd5998;
      8'd16:  t = 15'd6393;
      8'd17:  t = 15'd6786;
      8'd18:  t = 15'd7179;
      8'd19:  t = 15'd7571;
      8'd20:  t = 15'd7962;
      8'd21:  t = 15'd8351;
      8'd22:  t = 15'd8739;
      8'd23:  t = 15'd9126;
      8'd24:  t = 15'd9512;
      8'd25:  t = 15'd9896;
      8'd26:  t = 15'd10278;
      8'd27:  t = 15'd10659;
      8'd28:  t = 15'd11039;
      8'd29:  t = 15'd11417;
      8'd30:  t = 15'd11793;
      8'd31:  t = 15'd12167;
      8'd32:  t = 15'd12539;
      8'd33:  t = 15'd12910;
      8'd34:  t = 15'd13279;
      8'd35:  t = 15'd13645;
      8'd36:  t = 15'd14010;
      8'd37:  t = 15'd14372;
      8'd38:  t = 15'd14732;
      8'd39:  t = 15'd15090;
      8'd40:  t = 15'd15446;
      8'd41:  t = 15'd15800;
      8'd42:  t = 15'd16151;
      8'd43:  t = 15'd16499;
      8'd44:  t = 15'd16846;
      8'd45:  t = 15'd17189;
      8'd46:  t = 15'd17530;
      8'd47:  t = 15'd17869;
      8'd48:  t = 15'd18204;
      8'd49:  t = 15'd18537;
      8'd50:  t = 15'd18868;
      8'd51:  t = 15'd19195;
      8'd52:  t = 15'd19519;
      8'd53:  t = 15'd19841;
      8'd54:  t = 15'd20159;
      8'd55:  t = 15'd20475;
      8'd56:  t = 15'd20787;
      8'd57:  t = 15'd21096;
      8'd58:  t = 15'd21403;
      8'd59:  t = 15'd21705;
      8'd60:  t = 15'd22005;
      8'd61:  t = 15'd22301;
      8'd62:  t = 15'd22594;
      8'd63:  t = 15'd22884;
      8'd64:  t = 15'd23170;
      8'd65:  t = 15'd23452;
      8'd66:  t = 15'd23731;
      8'd67:  t = 15'd24007;
      8'd68:  t = 15'd24279;
      8'd69:  t = 15'd24547;
      8'd70:  t = 15'd24811;
      8'd71:  t = 15'd25072;
      8'd72:  t = 15'd25329;
      8'd73:  t = 15'd25582;
      8'd74:  t = 15'd25832;
      8'd75:  t = 15'd26077;
      8'd76:  t = 15'd26319;
      8'd77:  t = 15'd26556;
      8'd78:  t = 15'd26790;
      8'd79:  t = 15'd27019;
      8'd80:  t = 15'd27245;
      8'd81:  t = 15'd27466;
      8'd82:  t = 15'd27683;
      8'd83:  t = 15'd27896;
      8'd84:  t = 15'd28105;
      8'd85:  t = 15'd28310;
      8'd86:  t = 15'd28510;
      8'd87:  t = 15'd28706;
      8'd88:  t = 15'd28898;
      8'd89:  t = 15'd29085;
      8'd90:  t = 15'd29268;
      8'd91:  t = 15'd29447;
      8'd92:  t = 15'd29621;
      8'd93:  t = 15'd29791;
      8'd94:  t = 15'd29956;
      8'd95:  t = 15'd30117;
      8'd96:  t = 15'd30273;
      8'd97:  t = 15'd30424;
      8'd98:  t = 15'd30571;
      8'd99:  t = 15'd30714;
      8'd100: t = 15'd30852;
      8'd101: t = 15'd30985;
      8'd102: t = 15'd31113;
      8'd103: t = 15'd31237;
      8'd104: t = 15'd31356;
      8'd105: t = 15'd31470;
      8'd106: t = 15'd31580;
      8'd107: t = 15'd31685;
      8'd108: t = 15'd31785;
      8'd109: t = 15'd31880;
      8'd110: t = 15'd31971;
      8'd111: t = 15'd32057;
      8'd112: t = 15'd32137;
      8'd113: t = 15'd32213;
      8'd114: t = 15'd32285;
      8'd115: t = 15'd32351;
      8'd116: t = 15'd32412;
      8'd117: t = 15'd32469;
      8'd118: t = 15'd32521;
      8'd119: t = 15'd32567;
      8'd120: t = 15'd32609;
      8'd121: t = 15'd32646;
      8'd122: t = 15'd32678;
      8'd123: t = 15'd32705;
      8'd124: t = 15'd32728;
      8'd125: t = 15'd32745;
      8'd126: t = 15'd32757;
      8'd127: t = 15'd32765;
      default: t = 15'd32767;  // n = 128; larger indices never occur
    endcase
    return t;
  endfunction

  logic [6:0]  k;
  logic [5:0]  f;
  logic [14:0] t_lo;
  logic [14:0] t_hi;
  logic [8:0]  delta;
  logic [14:0] prod;
  logic [8:0]  frac_step;
  logic [15:0] sv_comb;

  // Table lookup of the two bracketing points and truncating linear interpolation
  always_comb begin
    k         = v[12:6];
    f         = v[5:0];
    t_lo      = quarter_sine({1'b0, k});
    t_hi      = quarter_sine({1'b0, k} + 8'd1);
    // Table is non-decreasing and steps are at most 402, so 9 bits hold the delta
    delta     = 9'(t_hi - t_lo);
    prod      = {6'd0, delta} * {9'd0, f};
    frac_step = 9'(prod >> 6);
    // Peak result is 32766, so no saturation is needed and bit 15 stays clear
    sv_comb   = {1'b0, t_lo + {6'd0, frac_step}};
  end

`ifdef SINE_LUT_PIPE_EN
  logic [15:0] sv_q;
  logic [15:0] sv_d;

  // Next-state for the output register
  always_comb begin
    sv_d = sv_comb;
  end

  // Output register, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_q <= '0;
    end else begin
      sv_q <= sv_d;
    end
  end

  assign sv = sv_q;
`else
  // Clock and reset are inert in the combinational build
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign sv = sv_comb;
`endif

endmodule

// File: tb/tb_sine_lut.sv
// tb_sine_lut: scoreboard bench for sine_lut. Stimulus pushes expected magnitudes into a
// queue tagged with the cycle they must appear; a negedge monitor pops and compares.
// Works for both builds (SINE_LUT_PIPE_EN defined or not).
`timescale 1ns/1ps
module tb_sine_lut;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] v;
  logic [15:0] sv;

  bit clk_en = 1'b1;
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

`ifdef SINE_LUT_PIPE_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 0;
`endif

  localparam real Pi = 3.14159265358979323846;

  typedef struct {
    int exp_sv;
    int vv;
    int due;
    bit sweep;
  } item_t;

  item_t sb_q[$];
  int    tbl[0:128];
  int    prev_sweep = 0;

  sine_lut dut (
    .clk (clk),
    .rst (rst),
    .v   (v),
    .sv  (sv)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: interpolate the ideal rounded table with plain integer arithmetic
  function automatic int ref_sv(input int vv);
    int kk = vv / 64;
    int ff = vv % 64;
    return tbl[kk] + ((tbl[kk + 1] - tbl[kk]) * ff) / 64;
  endfunction

  task automatic push(input int vv, input int exp_sv, input bit sweep);
    item_t it;
    @(posedge clk);
    #1;
    v         = 13'(vv);
    it.exp_sv = exp_sv;
    it.vv     = vv;
    it.due    = cyc + Lat;
    it.sweep  = sweep;
    sb_q.push_back(it);
  endtask

  // Monitor: compare every expected item in the cycle it is due
  always @(negedge clk) begin
    item_t it;
    real   ideal;
    real   err;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      it = sb_q.pop_front();
      check($sformatf("sv v=0x%04h", it.vv), int'(sv), it.exp_sv);
      if (it.sweep) begin
        check($sformatf("msb_clear v=%0d", it.vv), int'(sv[15]), 0);
        if (it.vv != 0) begin
          check($sformatf("monotonic v=%0d prev=%0d", it.vv, prev_sweep),
                int'(int'(sv) >= prev_sweep), 1);
        end
        prev_sweep = int'(sv);
        ideal = 32767.0 * $sin(Pi / 2.0 * real'(it.vv) / 8192.0);
        err   = real'(int'(sv)) - ideal;
        if (err < 0.0) err = -err;
        check($sformatf("within_3lsb v=%0d sv=%0d", it.vv, sv), int'(err <= 3.0), 1);
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int n = 0; n <= 128; n++) begin
      tbl[n] = $rtoi($floor(32767.0 * $sin(Pi / 2.0 * real'(n) / 128.0) + 0.5));
    end

    rst = 1'b0;
    v   = 13'h1000;
    #2 rst = 1'b1;
    #2;
`ifdef SINE_LUT_PIPE_EN
    check("reset_clears_sv", int'(sv), 0);
    @(posedge clk);
    #2 check("reset_holds_over_edge", int'(sv), 0);
`else
    check("reset_no_effect", int'(sv), 23170);
    @(posedge clk);
    #2 check("reset_no_effect_edge", int'(sv), 23170);
`endif
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("first_edge_after_release", int'(sv), 23170);

    // Directed table points, interpolation points, back-to-back and hold
    push(13'h0000, 0, 1'b0);
    push(13'h0800, 12539, 1'b0);
    push(13'h1000, 23170, 1'b0);
    push(13'h0020, 201, 1'b0);
    push(13'h1FFF, 32766, 1'b0);
    push(13'h1FC0, 32765, 1'b0);
    push(13'h1000, 23170, 1'b0);
    push(13'h0800, 12539, 1'b0);
    for (int i = 0; i < 4; i++) push(13'h0800, 12539, 1'b0);

    // Exhaustive sweep
    for (int vv = 0; vv < 8192; vv++) push(vv, ref_sv(vv), 1'b1);

    // Random phases
    for (int i = 0; i < 1500; i++) begin
      int vv;
      vv = int'($urandom_range(0, 8191));
      push(vv, ref_sv(vv), 1'b0);
    end

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
    #6;
    check("scoreboard_drained", sb_q.size(), 0);

`ifdef SINE_LUT_PIPE_EN
    @(posedge clk);
    #1 v = 13'h1000;
    @(posedge clk);
    #1 check("pipe_load", int'(sv), 23170);
    v = 13'h0800;
    #2 rst = 1'b1;
    #1 check("async_clear_mid_cycle", int'(sv), 0);
    @(posedge clk);
    #1 check("reset_discards_pending", int'(sv), 0);
    v = 13'h1000;
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check("release_then_load", int'(sv), 23170);
`else
    @(negedge clk);
    clk_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = (i % 2 == 1) ? 13'h1FFF : 13'h0000;
      #7 check($sformatf("clk_stopped_%0d", i), int'(sv), (i % 2 == 1) ? 32766 : 0);
    end
    rst = 1'b1;
    v   = 13'h1000;
    #3 check("rst_ignored_comb", int'(sv), 23170);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
